// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types and helpers for the sequence detector
//
// Purpose : detector state encoding, width derivation for the length field,
//           and a length-masked equality helper used by the comparator.
// Ports   : none (package).

package seq_detect_pkg;

  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    SEARCH = 2'd1,
    MATCH  = 2'd2
  } det_state_t;

  // Widest pattern the masked compare helper can handle.
  localparam int MAX_CMP_W = 64;

  // Bits needed to hold a length in 0..max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // True when the low 'len' bits of a and b agree; bits at or above len
  // are don't-care.
  function automatic logic masked_eq(input logic [MAX_CMP_W-1:0] a,
                                     input logic [MAX_CMP_W-1:0] b,
                                     input int unsigned          len);
    logic eq;
    eq = 1'b1;
    for (int unsigned i = 0; i < MAX_CMP_W; i++) begin
      if ((i < len) && (a[i] != b[i])) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// rtl/seq_match_cmp.sv - combinational length-masked window/pattern compare
//
// Purpose : reports whether the low len_i bits of the candidate window
//           equal the low len_i bits of the programmed pattern.
// Ports   : window_i  [MAX_LEN] candidate bits, newest at bit 0
//           pattern_i [MAX_LEN] programmed pattern, last bit at bit 0
//           len_i     [LEN_W]   number of low bits that take part
//           eq_o                1 when the masked bits agree

module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] window_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               eq_o
);

  logic [MAX_CMP_W-1:0] window_ext;
  logic [MAX_CMP_W-1:0] pattern_ext;

  always_comb begin
    window_ext                 = '0;
    pattern_ext                = '0;
    window_ext[MAX_LEN-1:0]    = window_i;
    pattern_ext[MAX_LEN-1:0]   = pattern_i;
    eq_o = masked_eq(window_ext, pattern_ext, 32'(len_i));
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - run-time programmable Moore serial sequence detector
//
// Purpose : detects a programmable bit pattern (1..MAX_LEN bits) on a
//           qualified serial stream, with optional overlapping matches and a
//           saturating match counter.
// Ports   : clk          rising-edge clock
//           areset       asynchronous active-high reset
//           cfg_load     strobe that latches cfg_pattern/cfg_len/cfg_overlap
//           cfg_pattern  [MAX_LEN] pattern, bit [len-1] arrives first
//           cfg_len      [LEN_W]   pattern length, valid 1..MAX_LEN
//           cfg_overlap  1 = overlapping matches allowed
//           in_valid     qualifies in
//           in           serial data bit
//           out          high exactly while in MATCH
//           match_count  [CNT_W]   saturating match count since load/reset
//           cfg_ok       high while a valid configuration is latched

module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_ok
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  det_state_t         state_q,   state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  // The oldest history bit would only ever be shifted out, so the window is
  // formed from MAX_LEN-1 stored bits plus the bit being accepted.
  logic [MAX_LEN-2:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic [CNT_W-1:0]   count_q,   count_d;

  logic [MAX_LEN-1:0] window;
  logic [LEN_W-1:0]   fill_inc;
  logic               accept;
  logic               fill_ok;
  logic               cmp_eq;
  logic               hit;
  logic               cfg_len_ok;

  assign window = {hist_q, in};
  assign accept = in_valid && (state_q != UNCFG) && !cfg_load;

  // Saturating fill+1. Since len never exceeds MAX_LEN, comparing the
  // saturated value against len is equivalent to (fill+1) >= len.
  assign fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
  assign fill_ok  = (fill_inc >= len_q);

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .window_i  (window),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .eq_o      (cmp_eq)
  );

  assign hit        = accept && fill_ok && cmp_eq;
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      state_d   = cfg_len_ok ? SEARCH : UNCFG;
    end else begin
      unique case (state_q)
        UNCFG:         state_d = UNCFG;
        SEARCH, MATCH: state_d = hit ? MATCH : SEARCH;
        default:       state_d = UNCFG;
      endcase

      if (accept) begin
        hist_d = window[MAX_LEN-2:0];
        // Non-overlapping mode restarts the fill so the next match needs
        // len fresh bits; history is kept but never compared until then.
        fill_d = (hit && !overlap_q) ? '0 : fill_inc;
      end

      if (hit && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

  assign out         = (state_q == MATCH);
  assign cfg_ok      = (state_q != UNCFG);
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - self-checking bench for seq_detect_fsm

module tb_seq_detect_fsm;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               areset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;

  logic               out_a, ok_a;
  logic [7:0]         cnt_a;
  logic               out_b, ok_b;
  logic [1:0]         cnt_b;

  seq_detect_fsm #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .areset(areset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in_bit),
    .out(out_a), .match_count(cnt_a), .cfg_ok(ok_a)
  );

  seq_detect_fsm #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .areset(areset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in_bit),
    .out(out_b), .match_count(cnt_b), .cfg_ok(ok_b)
  );

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: list of accepted bits plus a count of bits received
  // since the last clear (load or non-overlapping match).
  bit         m_cfg;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];
  int         m_fresh;
  int         m_cnt;
  bit         m_out;

  function automatic bit tail_matches();
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0;
    m_bits.delete(); m_fresh = 0; m_cnt = 0; m_out = 0;
  endtask

  task automatic model_step();
    if (cfg_load) begin
      m_cfg = (cfg_len >= 1) && (int'(cfg_len) <= MAX_LEN);
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_bits.delete(); m_fresh = 0; m_cnt = 0; m_out = 0;
    end else if (m_cfg && in_valid) begin
      m_bits.push_back(in_bit);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      m_fresh++;
      m_out = (m_fresh >= m_len) && tail_matches();
      if (m_out) begin
        m_cnt++;
        if (!m_ovl) m_fresh = 0;
      end
    end else begin
      m_out = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ":out"},      out_a, m_out);
    check({where, ":out_sat"},  out_b, m_out);
    check({where, ":cfg_ok"},   ok_a,  m_cfg);
    check({where, ":cnt"},      cnt_a, (m_cnt > 255) ? 255 : m_cnt);
    check({where, ":cnt_sat"},  cnt_b, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs("step");
    if (out_a) pulses++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = 1'b1; in_bit = 1'($urandom);
    step();
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send(input bit b);
    in_valid = 1'b1; in_bit = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_bit = 1'($urandom);
    step();
  endtask

  logic [4:0] obs5;
  logic [2:0] obs3;
  logic [7:0] a5;

  initial begin
    areset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    model_reset();
    do_reset();

    // No configuration: bits are never accepted.
    send(1); send(0); send(1);
    check("noload_out", out_a, 0);
    check("noload_cfg_ok", ok_a, 0);
    check("noload_cnt", cnt_a, 0);

    // 101 overlapping: pulses after bits 3 and 5.
    load(8'b0000_0101, 4'd3, 1'b1);
    a5 = 8'b0001_0101;
    for (int i = 4; i >= 0; i--) begin send(a5[i]); obs5[4 - i] = out_a; end
    check("ovl_pulses", obs5, 5'b10100);
    check("ovl_cnt", cnt_a, 2);

    // 101 non-overlapping, junk above len in the pattern: one pulse only.
    load(8'b1111_1101, 4'd3, 1'b0);
    for (int i = 4; i >= 0; i--) begin send(a5[i]); obs5[4 - i] = out_a; end
    check("novl_pulses", obs5, 5'b00100);
    check("novl_cnt", cnt_a, 1);

    // len=1: out held high across back-to-back matches.
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin send(1); obs3[i] = out_a; end
    check("len1_held", obs3, 3'b111);
    idle();
    check("len1_drop", out_a, 0);
    check("len1_cnt", cnt_a, 3);
    for (int i = 0; i < 3; i++) send(1);
    check("sat_cnt", cnt_b, 3);
    check("wide_cnt", cnt_a, 6);

    // Invalid length: unconfigured, count cleared, no pulses.
    load(8'h01, 4'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) send(1);
    check("len0_cfg_ok", ok_b, 0);
    check("len0_cnt", cnt_b, 0);
    check("len0_pulses", pulses, 0);

    // Full-width 0xA5 with gaps between bits.
    a5 = 8'hA5;
    load(a5, 4'd8, 1'b0);
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      send(a5[i]);
      check("a5_out", out_a, (i == 0) ? 1 : 0);
      idle();
    end
    check("a5_pulses", pulses, 1);

    // Reload mid-stream discards the first half of the pattern.
    load(a5, 4'd8, 1'b0);
    for (int i = 7; i >= 4; i--) send(a5[i]);
    load(a5, 4'd8, 1'b0);
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin send(a5[i]); idle(); end
    check("reload_partial", pulses, 0);
    for (int i = 7; i >= 0; i--) begin send(a5[i]); idle(); end
    check("reload_full", pulses, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      int l;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else if (r < 25) begin
        l = ($urandom % 2) ? $urandom_range(1, 3) : $urandom_range(0, 11);
        load(8'($urandom), 4'(l), 1'($urandom));
      end else if (r < 800) begin
        send(1'($urandom));
      end else begin
        idle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Parametrised, run-time-programmable Moore sequence detector; successor to the fixed 4-state "101" detector.
- Pattern, length (1..MAX_LEN) and overlap mode are loaded at run time; input bits are qualified by in_valid.
- Keeps a saturating match counter.
- Sits on serial control/status streams. The single-cycle out pulse drives downstream event logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match_count.
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- areset  input  1  asynchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe; latches cfg_* fields.
- cfg_pattern  input  MAX_LEN  pattern. Bit [len-1] is the first bit to arrive; bit [0] is the last.
- cfg_len  input  LEN_W  pattern length. Valid range is 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- in_valid  input  1  qualifies in.
- in  input  1  serial data bit.
- out  output  1  Moore match flag: high exactly while state==MATCH.
- match_count  output  CNT_W  number of matches since last load or reset; saturating.
- cfg_ok  output  1  high while the latched configuration is valid (state != UNCFG).

Behaviour:
- States: UNCFG, SEARCH, MATCH. out = (state==MATCH) and cfg_ok = (state!=UNCFG), both decoded from state only.
- Reset (async, immediate): state=UNCFG, pattern=0, len=0, overlap=0, hist=0, fill=0, match_count=0, out=0.
- Internal registers:
  - hist[MAX_LEN-1:0] holds received bits, newest at bit 0. On an accepted bit: hist <= {hist[MAX_LEN-2:0], in}.
  - fill counts accepted bits since the last clear and saturates at MAX_LEN.
- Accepted bit: in_valid=1 while state!=UNCFG and cfg_load=0.
- hit is asserted on an accepted bit when both hold:
  - (fill+1) >= len;
  - the low len bits of {hist[MAX_LEN-2:0], in} equal the low len bits of pattern.
- Transitions:
  - UNCFG: stays in UNCFG; never accepts bits.
  - SEARCH: hit -> MATCH; otherwise stays in SEARCH.
  - MATCH: hit -> MATCH (out stays high for back-to-back matches); otherwise -> SEARCH, including when in_valid=0. out is therefore never high longer than one cycle per match.
- Latency: out rises on the clock edge that accepts the completing bit, i.e. it is visible the cycle after that bit is presented. This is the same as the legacy detector.
- On hit:
  - match_count increments, saturating at all-ones.
  - If overlap=0, fill is cleared to 0 and hist is kept, so the next match needs len fresh bits.
  - If overlap=1, fill is kept.
- cfg_load (highest priority after reset, any state):
  - latches pattern, len and overlap;
  - clears hist, fill and match_count;
  - in/in_valid in that cycle are ignored;
  - next state: SEARCH if 1<=cfg_len<=MAX_LEN, otherwise UNCFG;
  - out=0 in the next cycle.
- len==MAX_LEN: the full hist window is compared. Pattern bits above len are don't-care.
- fill saturation must not wrap. Matches continue indefinitely in overlap mode.
- Reset asserted mid-sequence discards all progress and configuration. A cfg_load is required after reset before any match can occur.

Decomposition:
- Package seq_detect_pkg contains:
  - typedef enum logic [1:0] det_state_t {UNCFG, SEARCH, MATCH};
  - a localparam function for LEN_W;
  - a masked-compare function (len-bit mask generation).
- Optional sub-module seq_match_cmp: combinational masked comparison of window vs pattern under len. Everything else stays in seq_detect_fsm.

Test Plan:
- Reset then in_valid=1 with in=1,0,1 without any load -> out stays 0, cfg_ok=0, match_count=0.
- Load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 -> out high the cycle after bits 3 and 5; match_count=2.
- Same stream with overlap=0 -> only one pulse (after bit 3); match_count=1.
- len=1, pattern=1, overlap=1; stream 1,1,1 -> out held high for 3 consecutive cycles, then low after in_valid drops; match_count=3.
- pattern=8'hA5, len=8; stream 0xA5 with in_valid gaps between bits -> exactly one pulse, after the final bit. Also drive cfg_load mid-stream -> partial progress is discarded and the subsequent bits must form a full 8-bit match.
- CNT_W=2, len=1 pattern=1 overlap=1, 6 ones -> match_count saturates at 3. Then load with cfg_len=0 -> cfg_ok=0, count=0, and no further pulses.
